// File: rtl/aes_ctrl_pkg.sv
// Shared constants and types for the aes_128 sharing logic.
package aes_ctrl_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_KEY_W           = 128;
    localparam int AES_LATENCY_DEFAULT = 20;

    // Wide enough for any supported requester count (up to 8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Index width for n requesters; never below one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last winner.
module rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] ptr;

    // First valid requester after the pointer, wrapping; pause masks the grant only.
    always_comb begin
        int   idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                winner     = ID_W'(idx);
                grant[idx] = !pause;
            end
        end
    end

    // Pointer moves to the winner only when a block actually transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            ptr <= winner;
        end
    end

endmodule

// File: rtl/aes_128_arbiter.sv
// Shares one pipelined aes_128 core among several requesters and tags
// every returning ciphertext with the index of the requester that sent it.
module aes_128_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int AES_LATENCY = AES_LATENCY_DEFAULT,
    parameter int ID_W        = id_width(NUM_REQ),
    localparam int CNT_W      = $clog2(AES_LATENCY + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pause,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_state,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
    output logic [AES_BLOCK_W-1:0]         core_state,
    output logic [AES_KEY_W-1:0]           core_key,
    input  logic [AES_BLOCK_W-1:0]         core_out,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [AES_BLOCK_W-1:0]         rsp_data,
    output logic [CNT_W-1:0]               in_flight
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               xfer;
    tag_t               tag_in;
    tag_t               tags [AES_LATENCY+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .req_valid (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .winner    (winner)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign rsp_data  = core_out;

    // Tag entering the pipeline alongside the operands.
    always_comb begin
        tag_in               = '0;
        tag_in.valid         = xfer;
        tag_in.id[ID_W-1:0]  = winner;
    end

    // Operand registers feeding the core; idle cycles present zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state <= '0;
            core_key   <= '0;
        end else if (xfer) begin
            core_state <= req_state[int'(winner)*AES_BLOCK_W +: AES_BLOCK_W];
            core_key   <= req_key[int'(winner)*AES_KEY_W +: AES_KEY_W];
        end else begin
            core_state <= '0;
            core_key   <= '0;
        end
    end

    // Tag shift register; free-running because the core cannot stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= AES_LATENCY; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0] <= tag_in;
            for (int k = 1; k <= AES_LATENCY; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    // Response qualifier lines up with the core result one edge after the last tag stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= tags[AES_LATENCY].valid;
            rsp_id    <= tags[AES_LATENCY].id[ID_W-1:0];
        end
    end

    // Occupancy: a block leaves the count on the edge that raises its response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({xfer, tags[AES_LATENCY].valid})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule
